// File: rtl/ex_stage_pip_if.sv
// ex_stage_pip_if: ID/EX operand/control inputs and EX/MEM register outputs of the EX stage
interface ex_stage_pip_if #(parameter int XLEN = 32);
  logic            valid_in, flush, alu_src;
  logic [3:0]      alu_op;
  logic [2:0]      control_M_in;
  logic [1:0]      control_WB_in;
  logic [XLEN-1:0] rs1_data, rs2_data, imm, PC_in;
  logic [4:0]      rd_in;
  logic [1:0]      fwd_A, fwd_B;
  logic [XLEN-1:0] ALU_result_EXMEM_fwd, writeBack_MEMWB_fwd;
  logic            stall_out, valid_out, zero_out;
  logic [2:0]      control_M_out;
  logic [1:0]      control_WB_out;
  logic [XLEN-1:0] ALU_result_out, writeData_out, PC_branch_out;
  logic [4:0]      rd_out;
  modport master (
    output valid_in, flush, alu_src, alu_op, control_M_in, control_WB_in, rs1_data, rs2_data,
           imm, PC_in, rd_in, fwd_A, fwd_B, ALU_result_EXMEM_fwd, writeBack_MEMWB_fwd,
    input  stall_out, valid_out, zero_out, control_M_out, control_WB_out, ALU_result_out,
           writeData_out, PC_branch_out, rd_out
  );
  modport slave (
    input  valid_in, flush, alu_src, alu_op, control_M_in, control_WB_in, rs1_data, rs2_data,
           imm, PC_in, rd_in, fwd_A, fwd_B, ALU_result_EXMEM_fwd, writeBack_MEMWB_fwd,
    output stall_out, valid_out, zero_out, control_M_out, control_WB_out, ALU_result_out,
           writeData_out, PC_branch_out, rd_out
  );
endinterface

// File: rtl/ex_stage_pip.sv
// ex_stage_pip: RISC-V EX stage with forwarding, ALU, branch target and EX/MEM register.
// Define EX_MUL_EN to build the iterative shift-add multiplier that stalls upstream.
module ex_stage_pip #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 32
) (
  input logic           clock,
  input logic           reset_n,
  ex_stage_pip_if.slave bus
);
  if (MUL_CYCLES != XLEN) begin : g_cfg
    $error("MUL_CYCLES must equal XLEN");
  end
  logic [XLEN-1:0] op_a, fwd_b_val, op_b, alu_res, mul_res;
  logic            stall, valid_d;
  logic            valid_q, zero_q;
  logic [2:0]      ctrl_m_q;
  logic [1:0]      ctrl_wb_q;
  logic [XLEN-1:0] result_q, wdata_q, pc_br_q;
  logic [4:0]      rd_q;
  assign op_a = bus.fwd_A == 2'b01 ? bus.writeBack_MEMWB_fwd :
                bus.fwd_A == 2'b10 ? bus.ALU_result_EXMEM_fwd : bus.rs1_data;
  assign fwd_b_val = bus.fwd_B == 2'b01 ? bus.writeBack_MEMWB_fwd :
                     bus.fwd_B == 2'b10 ? bus.ALU_result_EXMEM_fwd : bus.rs2_data;
  assign op_b = bus.alu_src ? bus.imm : fwd_b_val;
  always_comb begin
    alu_res = '0;
    case (bus.alu_op)
      4'b0000: alu_res = op_a & op_b;
      4'b0001: alu_res = op_a | op_b;
      4'b0010: alu_res = op_a + op_b;
      4'b0110: alu_res = op_a - op_b;
      4'b0111: alu_res = XLEN'($signed(op_a) < $signed(op_b));
      4'b1000: alu_res = op_a ^ op_b;
      4'b1001: alu_res = op_a << op_b[4:0];
      4'b1010: alu_res = op_a >> op_b[4:0];
      4'b1011: alu_res = $signed(op_a) >>> op_b[4:0];
      4'b1100: alu_res = mul_res;
      default: alu_res = '0;
    endcase
  end
`ifdef EX_MUL_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int CW = $clog2(MUL_CYCLES);
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    stall    = 1'b0;
    case (state_q)
      IDLE: begin
        stall = bus.valid_in & (bus.alu_op == 4'b1100) & ~bus.flush;
        if (stall) begin
          state_d  = BUSY;
          cnt_d    = '0;
          acc_d    = '0;
          mcand_d  = op_a;
          mplier_d = op_b;
        end
      end
      BUSY: begin
        stall    = 1'b1;
        acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        state_d  = cnt_q == CW'(MUL_CYCLES - 1) ? DONE : BUSY;
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end
  // only the finished product ever reaches the result path
  assign mul_res = state_q == DONE ? acc_q : '0;
`else
  assign stall   = 1'b0;
  assign mul_res = '0;
`endif
  assign bus.stall_out = stall & reset_n;
  assign valid_d = bus.valid_in & ~stall & ~bus.flush;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      valid_q   <= 1'b0;
      ctrl_m_q  <= '0;
      ctrl_wb_q <= '0;
      zero_q    <= 1'b0;
      result_q  <= '0;
      wdata_q   <= '0;
      pc_br_q   <= '0;
      rd_q      <= '0;
    end else begin
      valid_q   <= valid_d;
      ctrl_m_q  <= valid_d ? bus.control_M_in : 3'b0;
      ctrl_wb_q <= valid_d ? bus.control_WB_in : 2'b0;
      zero_q    <= alu_res == '0;
      result_q  <= alu_res;
      wdata_q   <= fwd_b_val;
      pc_br_q   <= bus.PC_in + (bus.imm << 1);
      rd_q      <= bus.rd_in;
    end
  assign bus.valid_out      = valid_q;
  assign bus.control_M_out  = ctrl_m_q;
  assign bus.control_WB_out = ctrl_wb_q;
  assign bus.zero_out       = zero_q;
  assign bus.ALU_result_out = result_q;
  assign bus.writeData_out  = wdata_q;
  assign bus.PC_branch_out  = pc_br_q;
  assign bus.rd_out         = rd_q;
endmodule

// File: tb/tb_ex_stage_pip.sv
// tb_ex_stage_pip: directed vectors for ex_stage_pip, checked every cycle against a cycle-count model
module tb_ex_stage_pip;
`ifdef EX_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;
  ex_stage_pip_if #(.XLEN(32)) bif ();
  ex_stage_pip #(.XLEN(32), .MUL_CYCLES(32)) dut (.clock(clk), .reset_n(rst_n), .bus(bif));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int s;
    s = int'(b[4:0]);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a + ~b + 32'd1;
      4'b0111: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'b1000: return a ^ b;
      4'b1001: return a << s;
      4'b1010: return a >> s;
      4'b1011: return (a >> s) | ((a[31] && s != 0) ? ~(32'hFFFF_FFFF >> s) : 32'h0);
      default: return 32'h0;
    endcase
  endfunction

  // model: m_n counts edges since a MUL was accepted; 1..32 busy, 33 result ready
  logic [31:0] m_a, m_bf, m_b, m_res, m_prod;
  logic        m_stall, m_acc, m_mul;
  int          m_n;
  logic        e_valid, e_zero;
  logic [2:0]  e_cm;
  logic [1:0]  e_cwb;
  logic [31:0] e_res, e_wd, e_pc;
  logic [4:0]  e_rd;
  always_comb begin
    m_a = bif.fwd_A == 2'b01 ? bif.writeBack_MEMWB_fwd : bif.fwd_A == 2'b10 ? bif.ALU_result_EXMEM_fwd : bif.rs1_data;
    m_bf = bif.fwd_B == 2'b01 ? bif.writeBack_MEMWB_fwd : bif.fwd_B == 2'b10 ? bif.ALU_result_EXMEM_fwd : bif.rs2_data;
    m_b = bif.alu_src ? bif.imm : m_bf;
    m_mul = bif.alu_op == 4'b1100;
    m_stall = rst_n && MUL_EN && ((m_n == 0 && bif.valid_in && m_mul && !bif.flush) || (m_n >= 1 && m_n <= 32));
    m_acc = !m_stall && bif.valid_in && !bif.flush;
    m_res = m_mul ? ((MUL_EN && m_n == 33) ? m_prod : 32'h0) : alu_ref(bif.alu_op, m_a, m_b);
  end
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_n <= 0; m_prod <= '0;
      e_valid <= 1'b0; e_zero <= 1'b0; e_cm <= '0; e_cwb <= '0;
      e_res <= '0; e_wd <= '0; e_pc <= '0; e_rd <= '0;
    end else begin
      m_n <= bif.flush ? 0 : m_n == 0 ? ((MUL_EN && bif.valid_in && m_mul) ? 1 : 0) : m_n == 33 ? 0 : m_n + 1;
      m_prod <= m_n == 0 ? m_a * m_b : m_prod;
      e_valid <= m_acc;
      e_cm <= m_acc ? bif.control_M_in : 3'b0;
      e_cwb <= m_acc ? bif.control_WB_in : 2'b0;
      e_res <= m_res;
      e_zero <= m_res == 32'h0;
      e_wd <= m_bf;
      e_pc <= bif.PC_in + {bif.imm[30:0], 1'b0};
      e_rd <= bif.rd_in;
    end

  always @(negedge clk) begin
    chk("stall_out", {31'b0, bif.stall_out}, {31'b0, m_stall});
    chk("valid_out", {31'b0, bif.valid_out}, {31'b0, e_valid});
    chk("control_M_out", {29'b0, bif.control_M_out}, {29'b0, e_cm});
    chk("control_WB_out", {30'b0, bif.control_WB_out}, {30'b0, e_cwb});
    if (e_valid) begin
      chk("ALU_result_out", bif.ALU_result_out, e_res);
      chk("zero_out", {31'b0, bif.zero_out}, {31'b0, e_zero});
      chk("writeData_out", bif.writeData_out, e_wd);
      chk("PC_branch_out", bif.PC_branch_out, e_pc);
      chk("rd_out", {27'b0, bif.rd_out}, {27'b0, e_rd});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bif.valid_in = 1'b1; bif.flush = 1'b0; bif.alu_op = op; bif.alu_src = 1'b1;
    bif.fwd_A = 2'b00; bif.fwd_B = 2'b00; bif.rs1_data = a; bif.imm = b;
  endtask

  typedef struct { logic [3:0] op; logic [31:0] a, b, r; } vec_t;
  vec_t vecs [10] = '{
    '{4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000},
    '{4'b0001, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF},
    '{4'b1000, 32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0},
    '{4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001},
    '{4'b0111, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000},
    '{4'b1001, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000},
    '{4'b1010, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001},
    '{4'b0110, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF},
    '{4'b0011, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000},
    '{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bif.valid_in = 0; bif.flush = 0; bif.alu_op = 0; bif.alu_src = 0;
    bif.control_M_in = 0; bif.control_WB_in = 0; bif.rs1_data = 0; bif.rs2_data = 0;
    bif.imm = 0; bif.PC_in = 0; bif.rd_in = 0; bif.fwd_A = 0; bif.fwd_B = 0;
    bif.ALU_result_EXMEM_fwd = 0; bif.writeBack_MEMWB_fwd = 0;
    rst_n = 1'b0;
    step(); step();
    chk("reset valid_out", {31'b0, bif.valid_out}, 32'd0);
    chk("reset ALU_result_out", bif.ALU_result_out, 32'd0);
    chk("reset stall_out", {31'b0, bif.stall_out}, 32'd0);
    rst_n = 1'b1;
    step();
    set_op(4'b0010, 32'd5, 32'd7);
    bif.rd_in = 5'd3; bif.control_WB_in = 2'b10;
    step();
    chk("add result", bif.ALU_result_out, 32'd12);
    chk("add rd", {27'b0, bif.rd_out}, 32'd3);
    chk("add valid", {31'b0, bif.valid_out}, 32'd1);
    chk("add zero", {31'b0, bif.zero_out}, 32'd0);
    chk("add wb ctrl", {30'b0, bif.control_WB_out}, 32'd2);
    set_op(4'b0110, 32'd0, 32'd0);
    bif.alu_src = 1'b0; bif.fwd_A = 2'b10; bif.ALU_result_EXMEM_fwd = 32'd9;
    bif.fwd_B = 2'b01; bif.writeBack_MEMWB_fwd = 32'd9; bif.control_M_in = 3'b100;
    step();
    chk("sub fwd result", bif.ALU_result_out, 32'd0);
    chk("sub fwd zero", {31'b0, bif.zero_out}, 32'd1);
    chk("sub fwd ctrlM", {29'b0, bif.control_M_out}, 32'd4);
    set_op(4'b0010, 32'd1, 32'hFFFF_FFFC);
    bif.PC_in = 32'h40; bif.control_M_in = 3'b000;
    step();
    chk("branch target", bif.PC_branch_out, 32'h38);
    set_op(4'b1011, 32'h8000_0000, 32'd4);
    step();
    chk("sra", bif.ALU_result_out, 32'hF800_0000);
    set_op(4'b0010, 32'd8, 32'd4);
    bif.control_M_in = 3'b001; bif.fwd_B = 2'b10; bif.ALU_result_EXMEM_fwd = 32'hDEAD_BEEF;
    step();
    chk("store data", bif.writeData_out, 32'hDEAD_BEEF);
    chk("store addr", bif.ALU_result_out, 32'd12);
    chk("store ctrlM", {29'b0, bif.control_M_out}, 32'd1);
    bif.fwd_B = 2'b00; bif.control_M_in = 3'b000;
    foreach (vecs[i]) begin
      set_op(vecs[i].op, vecs[i].a, vecs[i].b);
      step();
      chk($sformatf("vec%0d result", i), bif.ALU_result_out, vecs[i].r);
    end
    set_op(4'b0010, 32'd1, 32'd1);
    bif.valid_in = 1'b0; bif.control_M_in = 3'b111; bif.control_WB_in = 2'b11;
    step();
    chk("bubble valid", {31'b0, bif.valid_out}, 32'd0);
    chk("bubble ctrlM", {29'b0, bif.control_M_out}, 32'd0);
    chk("bubble ctrlWB", {30'b0, bif.control_WB_out}, 32'd0);
    bif.valid_in = 1'b1; bif.flush = 1'b1;
    step();
    chk("flush valid", {31'b0, bif.valid_out}, 32'd0);
    chk("flush ctrlM", {29'b0, bif.control_M_out}, 32'd0);
    bif.flush = 1'b0; bif.control_M_in = 3'b000; bif.control_WB_in = 2'b01; bif.valid_in = 1'b0;
    step();
    set_op(4'b1100, 32'h0001_0001, 32'h0);
    bif.alu_src = 1'b0; bif.rs2_data = 32'h0003_0000;
    if (MUL_EN) begin
      n = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (!bif.stall_out) break;
        n++;
        chk("mul stall bubble", {31'b0, bif.valid_out}, 32'd0);
        @(posedge clk);
      end
      chk("mul stall cycles", n, 32'd33);
      step();
      bif.valid_in = 1'b0;
      chk("mul product", bif.ALU_result_out, 32'h0003_0000);
      chk("mul valid", {31'b0, bif.valid_out}, 32'd1);
      step();
      set_op(4'b1100, 32'h0001_0001, 32'h0);
      bif.alu_src = 1'b0;
      repeat (11) step();
      bif.flush = 1'b1;
      step();
      bif.flush = 1'b0; bif.valid_in = 1'b0;
      chk("mul flush stall", {31'b0, bif.stall_out}, 32'd0);
      chk("mul flush valid", {31'b0, bif.valid_out}, 32'd0);
      repeat (40) step();
      set_op(4'b1100, 32'h0001_0001, 32'h0);
      bif.alu_src = 1'b0;
      repeat (6) step();
      rst_n = 1'b0;
      #1;
      chk("mul reset stall", {31'b0, bif.stall_out}, 32'd0);
      chk("mul reset valid", {31'b0, bif.valid_out}, 32'd0);
      chk("mul reset result", bif.ALU_result_out, 32'd0);
      chk("mul reset pc", bif.PC_branch_out, 32'd0);
      bif.valid_in = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      set_op(4'b1100, 32'h0001_0001, 32'h0);
      bif.flush = 1'b1;
      step();
      chk("mul+flush valid", {31'b0, bif.valid_out}, 32'd0);
      bif.flush = 1'b0; bif.valid_in = 1'b0;
      #1;
      chk("mul+flush stall", {31'b0, bif.stall_out}, 32'd0);
    end else begin
      #1;
      chk("mul off stall", {31'b0, bif.stall_out}, 32'd0);
      step();
      chk("mul off result", bif.ALU_result_out, 32'd0);
      chk("mul off valid", {31'b0, bif.valid_out}, 32'd1);
      chk("mul off zero", {31'b0, bif.zero_out}, 32'd1);
      bif.valid_in = 1'b0;
    end
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_stage_pip.md
Name: ex_stage_pip

Overview:
- Execute stage of the 5-stage pipelined RISC-V core; sits directly upstream of the MEM stage and drives its inputs through the EX/MEM pipeline register.
- Performs forwarding-operand selection, the ALU operation, zero-flag generation and branch-target computation.
- Registers all results, including pass-through M/WB control, into EX/MEM, with stall-bubble and flush support.
- Hosts an optional iterative multiplier that stalls upstream while busy.

Parameters:
- XLEN, 32, datapath width
- MUL_CYCLES, 32, multiplier iterations (one multiplier bit per cycle); must equal XLEN

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- valid_in  in  1  ID/EX slot holds a real instruction
- flush  in  1  synchronous kill of the EX slot and EX/MEM register
- alu_op  in  4  operation select (encoding below)
- alu_src  in  1  1 = operand B from imm, 0 = forwarded rs2
- control_M_in  in  3  [2] Branch, [1] MemRead, [0] MemWrite; passed through
- control_WB_in  in  2  WB control; passed through
- rs1_data, rs2_data  in  XLEN  register-file operands
- imm  in  XLEN  sign-extended immediate
- PC_in  in  XLEN  instruction PC
- rd_in  in  5  destination register
- fwd_A, fwd_B  in  2  00 register file, 01 MEM/WB, 10 EX/MEM, 11 treated as 00
- ALU_result_EXMEM_fwd  in  XLEN  EX/MEM forwarded value
- writeBack_MEMWB_fwd  in  XLEN  MEM/WB forwarded value
- stall_out  out  1  combinational; upstream must hold ID/EX while high
- valid_out  out  1  EX/MEM slot valid
- control_M_out  out  3  registered control_M_in
- control_WB_out  out  2  registered control_WB_in
- zero_out  out  1  registered (ALU result == 0)
- ALU_result_out  out  XLEN  registered ALU result
- writeData_out  out  XLEN  registered forwarded rs2 (store data, pre-imm mux)
- PC_branch_out  out  XLEN  registered PC_in + (imm << 1)
- rd_out  out  5  registered rd_in

Behaviour:
- Reset (async, reset_n = 0): all registered outputs 0; FSM IDLE; counter 0. stall_out = 0 while in reset.
- ALU operand A = fwd_A-selected value. Operand B = imm if alu_src = 1, else the fwd_B-selected value.
- alu_op encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB
  - 0111 SLT (signed, result 1 or 0), 1000 XOR
  - 1001 SLL, 1010 SRL, 1011 SRA (shift amount = B[4:0])
  - 1100 MUL (low XLEN bits of the unsigned product)
  - any other code: result 0
- Arithmetic wraps modulo 2^XLEN. PC_branch wraps the same way.
- Single-cycle ops: latency 1. Values present at edge N appear on outputs after edge N.
- Invalid slot: valid_in = 0 loads a bubble.
  - Bubble = valid_out 0, control_M_out 0, control_WB_out 0.
  - Data fields are don't-care but deterministic (loaded normally).
- Multiplier FSM:
  - IDLE → BUSY when valid_in & alu_op = MUL & ~flush. Operands are latched and counter cleared on that edge.
  - BUSY: one shift-add step per cycle; counter increments.
  - BUSY → DONE when counter = MUL_CYCLES-1.
  - DONE: product is final; EX/MEM captures it with all pass-through fields.
  - DONE → IDLE unconditionally.
- stall_out = (IDLE & valid_in & alu_op = MUL) | BUSY.
- A MUL therefore occupies EX for 34 cycles: 1 IDLE + 32 BUSY + 1 DONE.
- Every edge while stall_out = 1 loads a bubble into EX/MEM.
- Flush: priority over stall and multiplier. EX/MEM loads a bubble; FSM returns to IDLE on that edge; stall_out drops next cycle.
- Reset mid-multiply: FSM to IDLE and outputs to 0 immediately; no partial result is ever emitted.
- Simultaneous valid_in MUL and flush in IDLE: the MUL is discarded and no stall occurs.
- zero_out is computed from the selected result in all cases, including MUL.

Optional Feature:
- Macro: EX_MUL_EN.
- Defined: the multiplier FSM is built as above.
- Undefined:
  - no FSM or counter hardware;
  - stall_out tied to 0;
  - alu_op 1100 gives result 0 in a single cycle, like other unused codes.

Test Plan:
- Reset then ADD: rs1_data = 5, imm = 7, alu_src = 1, valid_in = 1, rd_in = 3 → after 1 edge ALU_result_out = 12, rd_out = 3, valid_out = 1, zero_out = 0.
- Forwarding + SUB: fwd_A = 10, ALU_result_EXMEM_fwd = 9, fwd_B = 01, writeBack_MEMWB_fwd = 9, alu_op = 0110, control_M_in = 100 → ALU_result_out = 0, zero_out = 1, control_M_out = 100.
- Branch target: PC_in = 0x40, imm = 0xFFFFFFFC → PC_branch_out = 0x38. SRA of 0x80000000 by 4 → 0xF8000000.
- MUL (EX_MUL_EN): A = 0x10001, B = 0x30000, held while stalled.
  - stall_out high for 33 consecutive cycles;
  - valid_out 0 during them;
  - one edge after DONE, ALU_result_out = 0x30000 (low 32 bits of 0x300030000), valid_out = 1.
- Flush during MUL: assert flush at BUSY counter = 10 → next cycle stall_out = 0, valid_out = 0, FSM IDLE, no product output. Repeat with reset_n pulsed low at counter = 5 → all outputs 0 immediately.
- Store passthrough: control_M_in = 001, fwd_B = 10, ALU_result_EXMEM_fwd = 0xDEADBEEF, alu_src = 1, rs1_data = 8, imm = 4 → writeData_out = 0xDEADBEEF, ALU_result_out = 12, control_M_out = 001.
